// File: rtl/vga_timing_defs.sv
// Shared timing constants for the VGA raster generators: 640x480@60 defaults,
// sync polarity constants and the helper that derives H_TOTAL/V_TOTAL.
package vga_timing_defs;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_CNT_W    = 10;

  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/clk_en_div.sv
// Enabled clock divider: counts 0..DIV-1 while i_en is high and flags the
// terminal count as a tick. Also used by the RTC interface blocks.
module clk_en_div #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] L_LAST = DW'(DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_at_last;
  logic [DW-1:0] w_div_nx;

  assign w_div_nx = r_at_last ? '0 : r_div + DW'(1);

  // The terminal-count flag is kept as a register so the tick is a flop ANDed with en.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div     <= '0;
      r_at_last <= (DIV == 1);
    end else if (i_en) begin
      r_div     <= w_div_nx;
      r_at_last <= (w_div_nx == L_LAST);
    end
  end

  assign o_tick = i_en & r_at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA raster timing generator with registered, aligned outputs.
// Optional 16-bit frame counter output when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_timing_defs::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter bit HS_POL   = SYNC_ACTIVE_LOW,
  parameter bit VS_POL   = SYNC_ACTIVE_LOW,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             px_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (CNT_W < 1 || (CNT_W < 31 && (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)))) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  localparam logic [CNT_W-1:0] L_H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] L_V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] L_HS_FIRST = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] L_HS_LAST  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] L_VS_FIRST = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] L_VS_LAST  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic             w_tick;
  logic             w_x_wrap;
  logic [CNT_W-1:0] w_nx_x;
  logic [CNT_W-1:0] w_nx_y;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_von;

  logic             r_px_en;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic [CNT_W-1:0] r_px_x;
  logic [CNT_W-1:0] r_px_y;
  logic             r_line_start;
  logic             r_frame_start;

  clk_en_div #(
    .DIV(CLK_DIV)
  ) u_div (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .o_tick(w_tick)
  );

  // Next coordinates are decoded combinationally so syncs register with no skew.
  assign w_x_wrap = (r_px_x == L_H_LAST);
  assign w_nx_x   = w_x_wrap ? '0 : r_px_x + CNT_W'(1);
  assign w_nx_y   = !w_x_wrap ? r_px_y :
                    (r_px_y == L_V_LAST) ? '0 : r_px_y + CNT_W'(1);
  assign w_hs_act = (w_nx_x >= L_HS_FIRST) && (w_nx_x <= L_HS_LAST);
  assign w_vs_act = (w_nx_y >= L_VS_FIRST) && (w_nx_y <= L_VS_LAST);
  assign w_von    = (w_nx_x < L_H_ACT) && (w_nx_y < L_V_ACT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px_x        <= L_H_LAST;
      r_px_y        <= L_V_LAST;
      r_px_en       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_video_on    <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
    end else begin
      r_px_en       <= w_tick;
      r_line_start  <= w_tick && w_x_wrap;
      r_frame_start <= w_tick && w_x_wrap && (w_nx_y == '0);
      if (w_tick) begin
        r_px_x     <= w_nx_x;
        r_px_y     <= w_nx_y;
        r_hsync    <= w_hs_act ? HS_POL : ~HS_POL;
        r_vsync    <= w_vs_act ? VS_POL : ~VS_POL;
        r_video_on <= w_von;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_tick && w_x_wrap && (w_nx_y == '0)) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign px_en       = r_px_en;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign px_x        = r_px_x;
  assign px_y        = r_px_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three configurations (default 640x480,
// a tiny CLK_DIV=1 raster, a small CLK_DIV=3 raster) against a raster-position model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hsw, hb;
    int va, vf, vsw, vb;
    int div;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    int   x, y, fc;
    logic pe, hs, vs, von, ls, fs;
  } st_t;

  logic clk;
  logic rst;
  logic en_v [3];

  logic       pe0, hs0, vs0, von0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       pe1, hs1, vs1, von1, ls1, fs1;
  logic [2:0] x1, y1;
  logic       pe2, hs2, vs2, von2, ls2, fs2;
  logic [4:0] x2, y2;
  logic [15:0] fc0, fc1, fc2;

  cfg_t cfg [3];
  int   enc [3];
  int   n   [3];
  bit   tk  [3];
  int   cyc;
  int   checks;
  int   errors;

  vga_timing_gen u0 (
    .clk(clk), .rst(rst), .en(en_v[0]),
    .px_en(pe0), .hsync(hs0), .vsync(vs0), .video_on(von0),
    .px_x(x0), .px_y(y0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(3)
  ) u1 (
    .clk(clk), .rst(rst), .en(en_v[1]),
    .px_en(pe1), .hsync(hs1), .vsync(vs1), .video_on(von1),
    .px_x(x1), .px_y(y1), .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(5), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(5)
  ) u2 (
    .clk(clk), .rst(rst), .en(en_v[2]),
    .px_en(pe2), .hsync(hs2), .vsync(vs2), .video_on(von2),
    .px_x(x2), .px_y(y2), .line_start(ls2), .frame_start(fs2)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc2)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fc0 = '0;
  assign fc1 = '0;
  assign fc2 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Expected outputs follow purely from how many pixel ticks have elapsed.
  function automatic st_t model(input int i);
    st_t  e;
    cfg_t c;
    int   ht, vt, p;
    c  = cfg[i];
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    if (n[i] == 0) begin
      e.x = ht - 1; e.y = vt - 1; e.fc = 0;
      e.hs = ~c.hp; e.vs = ~c.vp; e.von = 1'b0;
    end else begin
      p    = (n[i] - 1) % (ht * vt);
      e.x  = p % ht;
      e.y  = p / ht;
      e.fc = ((n[i] - 1) / (ht * vt) + 1) % 65536;
      e.hs = (e.x >= c.ha + c.hf && e.x <= c.ha + c.hf + c.hsw - 1) ? c.hp : ~c.hp;
      e.vs = (e.y >= c.va + c.vf && e.y <= c.va + c.vf + c.vsw - 1) ? c.vp : ~c.vp;
      e.von = (e.x < c.ha) && (e.y < c.va);
    end
    e.pe = tk[i];
    e.ls = tk[i] && (e.x == 0);
    e.fs = e.ls && (e.y == 0);
    return e;
  endfunction

  function automatic st_t get_act(input int i);
    st_t a;
    case (i)
      0: begin
        a.x = int'(x0); a.y = int'(y0); a.fc = int'(fc0);
        a.pe = pe0; a.hs = hs0; a.vs = vs0; a.von = von0; a.ls = ls0; a.fs = fs0;
      end
      1: begin
        a.x = int'(x1); a.y = int'(y1); a.fc = int'(fc1);
        a.pe = pe1; a.hs = hs1; a.vs = vs1; a.von = von1; a.ls = ls1; a.fs = fs1;
      end
      default: begin
        a.x = int'(x2); a.y = int'(y2); a.fc = int'(fc2);
        a.pe = pe2; a.hs = hs2; a.vs = vs2; a.von = von2; a.ls = ls2; a.fs = fs2;
      end
    endcase
    return a;
  endfunction

  task automatic checkOutput();
    st_t e, a;
    for (int i = 0; i < 3; i++) begin
      e = model(i);
      a = get_act(i);
      chk($sformatf("u%0d.px_en", i),       {31'd0, a.pe},  {31'd0, e.pe});
      chk($sformatf("u%0d.px_x", i),        a.x,            e.x);
      chk($sformatf("u%0d.px_y", i),        a.y,            e.y);
      chk($sformatf("u%0d.hsync", i),       {31'd0, a.hs},  {31'd0, e.hs});
      chk($sformatf("u%0d.vsync", i),       {31'd0, a.vs},  {31'd0, e.vs});
      chk($sformatf("u%0d.video_on", i),    {31'd0, a.von}, {31'd0, e.von});
      chk($sformatf("u%0d.line_start", i),  {31'd0, a.ls},  {31'd0, e.ls});
      chk($sformatf("u%0d.frame_start", i), {31'd0, a.fs},  {31'd0, e.fs});
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk($sformatf("u%0d.frame_cnt", i),   a.fc,           e.fc);
`endif
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      enc[i] = 0; n[i] = 0; tk[i] = 1'b0;
    end
  endtask

  // One clock: advance the model with the enables seen at posedge, compare at negedge.
  task automatic applyStimulus();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      tk[i] = 1'b0;
      if (en_v[i]) begin
        enc[i]++;
        if (enc[i] % cfg[i].div == 0) begin
          tk[i] = 1'b1;
          n[i]++;
        end
      end
    end
    cyc++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    checkOutput();
    #1 rst = 1'b0;
  endtask

  initial begin
    int last_ls, last_fs1, first_pe, hs_low, von_low, vs_act2, bound;
    checks = 0; errors = 0; cyc = 0;
    cfg[0] = '{ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33, div:2, hp:1'b0, vp:1'b0};
    cfg[1] = '{ha:4, hf:1, hsw:1, hb:1, va:4, vf:1, vsw:1, vb:1, div:1, hp:1'b1, vp:1'b1};
    cfg[2] = '{ha:8, hf:2, hsw:3, hb:2, va:5, vf:2, vsw:2, vb:3, div:3, hp:1'b0, vp:1'b1};
    model_reset();
    for (int i = 0; i < 3; i++) en_v[i] = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput();
    chk("reset.px_x", int'(x0), 799);
    chk("reset.px_y", int'(y0), 524);
    chk("reset.hsync", {31'd0, hs0}, 1);
    chk("reset.vsync_u1", {31'd0, vs1}, 0);
    rst = 1'b0;

    // Free-running sweep with en held high.
    last_ls = -1; last_fs1 = -1; first_pe = -1;
    hs_low = 0; von_low = 0; vs_act2 = 0;
    for (int k = 0; k < 3300; k++) begin
      applyStimulus();
      if (pe0 && first_pe < 0) begin
        first_pe = cyc;
        chk("first.cycle", first_pe, 2);
        chk("first.px_x", int'(x0), 0);
        chk("first.px_y", int'(y0), 0);
        chk("first.frame_start", {31'd0, fs0}, 1);
        chk("first.video_on", {31'd0, von0}, 1);
      end
      if (ls0) begin
        if (last_ls >= 0) chk("line_start.period", cyc - last_ls, 1600);
        last_ls = cyc;
      end
      if (fs1) begin
        if (last_fs1 >= 0) chk("u1.frame_period", cyc - last_fs1, 49);
        last_fs1 = cyc;
      end
      if (pe1) chk("u1.px_en_every_cycle", {31'd0, pe1}, 1);
      if (pe0 && y0 == 10'd1 && !hs0) hs_low++;
      if (pe0 && y0 == 10'd1 && !von0) von_low++;
      if (pe2 && vs2 && cyc <= 540) vs_act2++;
    end
    chk("line1.hsync_low_ticks", hs_low, 96);
    chk("line1.video_off_ticks", von_low, 160);
    chk("u2.frame1_vsync_ticks", vs_act2, 30);

    // Freeze at px_x=300 one clock into the divider phase.
    bound = 0;
    while (!(pe0 && x0 == 10'd300) && bound < 4000) begin
      applyStimulus();
      bound++;
    end
    chk("freeze.reach_300", {31'd0, (bound < 4000)}, 1);
    applyStimulus();
    en_v[0] = 1'b0;
    for (int k = 0; k < 37; k++) begin
      applyStimulus();
      chk("freeze.px_en", {31'd0, pe0}, 0);
      chk("freeze.px_x", int'(x0), 300);
    end
    en_v[0] = 1'b1;
    applyStimulus();
    chk("resume.px_en", {31'd0, pe0}, 1);
    chk("resume.px_x", int'(x0), 301);

    // Mid-frame asynchronous reset, then resynchronisation on the first tick.
    bound = 0;
    while (y2 != 5'd5 && bound < 1000) begin
      applyStimulus();
      bound++;
    end
    rst_pulse();
    chk("midrst.px_x", int'(x0), 799);
    chk("midrst.frame_start", {31'd0, fs0}, 0);
    bound = 0;
    applyStimulus();
    while (!pe0 && bound < 10) begin
      applyStimulus();
      bound++;
    end
    chk("midrst.first_tick_seen", {31'd0, pe0}, 1);
    chk("midrst.frame_start", {31'd0, fs0}, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("midrst.frame_cnt", int'(fc0), 1);
`endif

    // Randomised enables with occasional asynchronous reset pulses.
    for (int k = 0; k < 20000; k++) begin
      for (int i = 0; i < 3; i++) en_v[i] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2999) == 0) rst_pulse();
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator. It is the next generation of the team's fixed 640x480 sync block.
- Generates pixel-enable, hsync, vsync, active-video flag, pixel coordinates, and line/frame start strobes.
- Supports any resolution, clock divide ratio and sync polarity.
- Sits between the system clock domain and the pixel/character renderers. Renderers and RTC display logic qualify all work with px_en.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (>=1)
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync (0 = active-low)
- CNT_W, 10, width of px_x/px_y; must hold H_TOTAL-1 and V_TOTAL-1 (H_TOTAL = sum of H_*, V_TOTAL = sum of V_*)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes timing
- px_en  out  1  one-clk pixel strobe; new coordinates valid this cycle
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- video_on  out  1  high while px_x<H_ACTIVE and px_y<V_ACTIVE
- px_x  out  CNT_W  current column
- px_y  out  CNT_W  current row
- line_start  out  1  one-clk pulse when px_x becomes 0
- frame_start  out  1  one-clk pulse when px_x and px_y both become 0

Behaviour:
- One clock (clk). Reset is asynchronous and active-high on rst. All state is cleared the instant rst rises.
- Reset values:
  - Divider = 0, px_x = H_TOTAL-1, px_y = V_TOTAL-1.
  - px_en = 0, line_start = 0, frame_start = 0, video_on = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
- Consequence: the first pixel tick after reset lands on (0,0) with frame_start set.
- Divider:
  - div counts 0..CLK_DIV-1 while en=1 and wraps.
  - tick = en && (div==CLK_DIV-1).
  - CLK_DIV=1 gives a tick on every enabled cycle.
- On tick, px_x advances; at H_TOTAL-1 it wraps to 0 and px_y advances.
- px_y wraps to 0 after V_TOTAL-1 when px_x wraps.
- All outputs are registered and aligned with each other. On the edge where tick is sampled:
  - px_x and px_y take their new values.
  - px_en=1 for exactly one clk.
  - hsync, vsync and video_on are decoded from the NEW coordinates in the same edge (no skew between coordinates and syncs).
- hsync active iff H_ACTIVE+H_FRONT <= px_x <= H_ACTIVE+H_FRONT+H_SYNC-1.
- vsync active iff V_ACTIVE+V_FRONT <= px_y <= V_ACTIVE+V_FRONT+V_SYNC-1. vsync changes only on the tick where px_x wraps to 0.
- line_start = tick && new px_x==0. frame_start = line_start && new px_y==0.
- All strobes (px_en, line_start, frame_start) are zero on every non-tick cycle.
- en low:
  - div, px_x, px_y, hsync, vsync and video_on hold.
  - px_en and the strobes are 0.
  - Resuming continues from the held div value; no pixel is skipped or repeated.
- rst mid-frame: immediate return to reset values regardless of div phase. Resynchronisation starts with frame_start on the first tick after rst falls.
- Counter arithmetic is unsigned, CNT_W bits. Compare against H_TOTAL-1 and V_TOTAL-1 exactly; never rely on overflow wrap.
- Elaboration check: a parameter combination violating CNT_W capacity or CLK_DIV<1 shall fail elaboration (generate-time error).

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt (16 bits), reset 0.
  - It increments (mod 2^16) in the same edge frame_start is asserted, so it reads 1 during the first frame after reset.
  - Frozen while en=0.
- Undefined: no port, no logic; all other behaviour is identical.

Decomposition:
- Shared package/header vga_timing_defs holds:
  - default 640x480@60 timing constants;
  - derived H_TOTAL and V_TOTAL macros;
  - polarity constants SYNC_ACTIVE_LOW and SYNC_ACTIVE_HIGH.
- One sub-module, clk_en_div: parametrised CLK_DIV counter with en input and registered tick output. It is reusable by the RTC interface blocks.
- The raster counters and decode stay in vga_timing_gen.

Test Plan:
- Defaults, en=1, release rst:
  - first px_en on clk 2 after release, with px_x=0, px_y=0, frame_start=1, video_on=1;
  - next frame_start exactly 840000 clk later (800*525*2).
- Defaults, line sweep:
  - hsync=0 exactly for px_x 656..751, i.e. 96 ticks;
  - video_on=0 from px_x=640 to 799;
  - line_start once per 1600 clk.
- Defaults, frame sweep: vsync=0 only on lines 490..491 (1600 ticks total), asserted at the tick where px_x wraps to 0 on line 490.
- CLK_DIV=1, HS_POL=1, VS_POL=1, all porches 1/sync 1/active 4:
  - H_TOTAL=7, px_en high every cycle;
  - hsync=1 only at px_x=5;
  - frame_start every 49 clk.
- en toggled low for 37 clk at px_x=300, mid-divider phase: outputs frozen and px_en=0; after resume, px_x=301 appears after exactly the remaining divider cycles.
- rst pulsed asynchronously (between edges) at px_y=200: all outputs take reset values immediately; first tick after release gives frame_start, and frame_cnt=1 when VGA_TIMING_FRAME_CNT_EN is defined.
